// File: rtl/clz_clo_pipe_unit.sv
// Two-stage pipelined leading-zero / leading-one counter (MIPS CLZ/CLO) for EX.
// Stage 1 registers per-byte leading-zero counts of the (optionally inverted)
// operand; stage 2 merges them into the final count and normalises the operand.
module clz_clo_pipe_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          NORM_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_op,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_count,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  output logic [DATA_W-1:0]     out_norm,
  output logic                  s1_busy
);

  localparam int unsigned NBYTE  = DATA_W / 8;
  localparam int unsigned BCNT_W = 4;
  localparam int unsigned CNT_W  = 6;

  // Only a 32-bit datapath is supported; stop elaboration for anything else.
  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("clz_clo_pipe_unit: DATA_W must be 32");
    end
  endgenerate

  // Leading zeros of one byte, 0..8.
  function automatic logic [BCNT_W-1:0] clz8(input logic [7:0] b);
    logic [BCNT_W-1:0] n;
    logic              done;
    n    = '0;
    done = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!done) begin
        if (b[i]) done = 1'b1;
        else      n    = n + BCNT_W'(1);
      end
    end
    return n;
  endfunction

  // Stage-1 registers
  logic                         r_s1_valid;
  logic [DATA_W-1:0]            r_s1_orig;
  logic [REG_ADDR_W-1:0]        r_s1_rd;
  logic [NBYTE-1:0][BCNT_W-1:0] r_s1_bcnt;

  // Stage-2 (output) registers
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_count;
  logic [REG_ADDR_W-1:0] r_out_rd;
  logic                  r_out_wen;
  logic [DATA_W-1:0]     r_out_norm;

  // Stage-1 combinational byte counters
  logic [DATA_W-1:0]            w_src;
  logic [NBYTE-1:0][BCNT_W-1:0] w_bcnt;

  // Stage-2 combinational merge and normaliser
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_norm;
  logic              w_s1_accept;

  // CLO is CLZ of the inverted operand; count leading zeros of each byte.
  always_comb begin
    w_src  = in_op ? ~in_data : in_data;
    w_bcnt = '0;
    for (int k = 0; k < int'(NBYTE); k++) begin
      w_bcnt[k] = clz8(w_src[8*k +: 8]);
    end
  end

  assign w_s1_accept = in_valid & ~stall & ~flush;

  // Stage 1: flush clears validity even under stall; data captured only for a live op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_orig  <= '0;
      r_s1_rd    <= '0;
      r_s1_bcnt  <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (!stall) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_accept) begin
        r_s1_orig <= in_data;
        r_s1_rd   <= in_rd;
        r_s1_bcnt <= w_bcnt;
      end
    end
  end

  // Merge byte counts: the most significant byte that is not all-zero decides.
  always_comb begin
    w_count = CNT_W'(DATA_W);
    for (int k = 0; k < int'(NBYTE); k++) begin
      if (r_s1_bcnt[k] != BCNT_W'(8)) begin
        w_count = CNT_W'(8 * (int'(NBYTE) - 1 - k)) + CNT_W'(r_s1_bcnt[k]);
      end
    end
    w_norm = '0;
    if (NORM_EN && (w_count < CNT_W'(DATA_W))) begin
      w_norm = r_s1_orig << w_count;
    end
  end

  // Stage 2: valid/wen advance every unstalled cycle; data only for a valid op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_wen   <= 1'b0;
      r_out_count <= '0;
      r_out_rd    <= '0;
      r_out_norm  <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
        r_out_wen   <= 1'b0;
      end else if (!stall) begin
        r_out_valid <= r_s1_valid;
        r_out_wen   <= r_s1_valid & (r_s1_rd != '0);
        if (r_s1_valid) begin
          r_out_count <= DATA_W'(w_count);
          r_out_rd    <= r_s1_rd;
          r_out_norm  <= w_norm;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_rd    = r_out_rd;
  assign out_wen   = r_out_wen;
  assign out_norm  = r_out_norm;
  assign s1_busy   = r_s1_valid;

endmodule

// File: tb/tb_clz_clo_pipe_unit.sv
// Self-checking bench for clz_clo_pipe_unit: vector table, directed
// stall/flush/reset sequences and a randomized run against a reference model.
module tb_clz_clo_pipe_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_op;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic [31:0] out_count;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_norm;
  logic        s1_busy;

  int checks;
  int failures;

  clz_clo_pipe_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_count (out_count),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .out_norm  (out_norm),
    .s1_busy   (s1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] d;
    logic [4:0]  rd;
    logic [31:0] cnt;
    logic [31:0] norm;
    logic        wen;
  } vec_t;

  typedef struct {
    bit          v;
    logic        op;
    logic [31:0] d;
    logic [4:0]  rd;
  } op_t;

  vec_t tbl[10];
  op_t  hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leading bits equal to the op's target value (0 for CLZ, 1 for CLO).
  function automatic int ref_count(input logic op, input logic [31:0] d);
    int n;
    n = 0;
    while (n < 32 && d[31-n] == op) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] d, input int n);
    if (n >= 32) return 32'h0;
    return d << n;
  endfunction

  task automatic drive(input logic v, input logic op, input logic [31:0] d, input logic [4:0] rd);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_rd    = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_count"}, out_count, 32'h0);
    chk({tag, "_rd"},    32'(out_rd), 32'h0);
    chk({tag, "_wen"},   32'(out_wen), 32'h0);
    chk({tag, "_norm"},  out_norm, 32'h0);
    chk({tag, "_busy"},  32'(s1_busy), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    idle();

    tbl[0] = '{1'b0, 32'h0000_0000, 5'd1, 32'd32, 32'h0000_0000, 1'b1};
    tbl[1] = '{1'b0, 32'h0000_0001, 5'd2, 32'd31, 32'h8000_0000, 1'b1};
    tbl[2] = '{1'b0, 32'h0000_8000, 5'd3, 32'd16, 32'h8000_0000, 1'b1};
    tbl[3] = '{1'b0, 32'h8000_0000, 5'd4, 32'd0,  32'h8000_0000, 1'b1};
    tbl[4] = '{1'b0, 32'h00FF_0000, 5'd5, 32'd8,  32'hFF00_0000, 1'b1};
    tbl[5] = '{1'b1, 32'hFFFF_FFFF, 5'd6, 32'd32, 32'h0000_0000, 1'b1};
    tbl[6] = '{1'b1, 32'hFFF0_0000, 5'd7, 32'd12, 32'h0000_0000, 1'b1};
    tbl[7] = '{1'b1, 32'h7FFF_FFFF, 5'd8, 32'd0,  32'h7FFF_FFFF, 1'b1};
    tbl[8] = '{1'b0, 32'h0000_0001, 5'd0, 32'd31, 32'h8000_0000, 1'b0};
    tbl[9] = '{1'b0, 32'h0000_0001, 5'd5, 32'd31, 32'h8000_0000, 1'b1};

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // Back-to-back table sweep; each result one edge after its capture edge
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, tbl[i].op, tbl[i].d, tbl[i].rd);
      else        idle();
      tick();
      if (i >= 1) begin
        chk($sformatf("tbl%0d_valid", i-1), 32'(out_valid), 32'h1);
        chk($sformatf("tbl%0d_count", i-1), out_count, tbl[i-1].cnt);
        chk($sformatf("tbl%0d_norm",  i-1), out_norm,  tbl[i-1].norm);
        chk($sformatf("tbl%0d_rd",    i-1), 32'(out_rd), 32'(tbl[i-1].rd));
        chk($sformatf("tbl%0d_wen",   i-1), 32'(out_wen), 32'(tbl[i-1].wen));
      end
    end
    tick();
    chk("tbl_drain_valid", 32'(out_valid), 32'h0);

    // Stall with an op in stage 1; input offered during stall must be ignored
    drive(1'b1, 1'b0, 32'h0000_0F00, 5'd9);
    tick();
    chk("stall_s1_busy", 32'(s1_busy), 32'h1);
    stall = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_frozen_valid", 32'(out_valid), 32'h0);
      chk("stall_frozen_busy",  32'(s1_busy), 32'h1);
    end
    stall = 1'b0;
    idle();
    tick();
    chk("stall_a_valid", 32'(out_valid), 32'h1);
    chk("stall_a_count", out_count, 32'd20);
    chk("stall_a_rd",    32'(out_rd), 32'd9);
    chk("stall_a_norm",  out_norm, 32'hF000_0000);
    tick();
    chk("stall_no_dup",  32'(out_valid), 32'h0);

    // Stall with a result sitting at the output
    drive(1'b1, 1'b1, 32'hFF00_0000, 5'd11);
    tick();
    idle();
    tick();
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_count", out_count, 32'd8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_stall_valid", 32'(out_valid), 32'h1);
      chk("hold_stall_count", out_count, 32'd8);
      chk("hold_stall_wen",   32'(out_wen), 32'h1);
    end
    stall = 1'b0;
    tick();
    chk("hold_release", 32'(out_valid), 32'h0);

    // Flush with B in stage 1 and A at the output
    drive(1'b1, 1'b0, 32'h0000_00F0, 5'd12);
    tick();
    drive(1'b1, 1'b0, 32'h0000_F000, 5'd13);
    tick();
    chk("flush_a_visible", out_count, 32'd24);
    flush = 1'b1;
    idle();
    tick();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_wen",   32'(out_wen), 32'h0);
    chk("flush_busy",  32'(s1_busy), 32'h0);
    flush = 1'b0;
    tick();
    chk("flush_b_dropped", 32'(out_valid), 32'h0);
    drive(1'b1, 1'b1, 32'hF000_0000, 5'd14);
    tick();
    idle();
    tick();
    chk("flush_c_valid", 32'(out_valid), 32'h1);
    chk("flush_c_count", out_count, 32'd4);
    chk("flush_c_rd",    32'(out_rd), 32'd14);
    chk("flush_c_wen",   32'(out_wen), 32'h1);
    chk("flush_c_norm",  out_norm, 32'h0);

    // Flush together with stall: flush wins
    drive(1'b1, 1'b0, 32'h0000_0010, 5'd15);
    tick();
    idle();
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_stall_busy",  32'(s1_busy), 32'h0);
    chk("flush_stall_valid", 32'(out_valid), 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    chk("flush_stall_after", 32'(out_valid), 32'h0);

    // Flush together with in_valid: incoming op dropped
    flush = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0004, 5'd16);
    tick();
    chk("flush_in_busy", 32'(s1_busy), 32'h0);
    flush = 1'b0;
    idle();
    tick();
    chk("flush_in_valid", 32'(out_valid), 32'h0);

    // Reset mid-operation with two ops in flight
    drive(1'b1, 1'b0, 32'h0000_0100, 5'd16);
    tick();
    drive(1'b1, 1'b0, 32'h0000_0002, 5'd17);
    tick();
    rst_n = 1'b0;
    idle();
    tick();
    chk_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_valid", 32'(out_valid), 32'h0);
      chk("postrst_count", out_count, 32'h0);
    end
    drive(1'b1, 1'b1, 32'h8000_0000, 5'd18);
    tick();
    idle();
    tick();
    chk("postrst_op_valid", 32'(out_valid), 32'h1);
    chk("postrst_op_count", out_count, 32'd1);
    chk("postrst_op_rd",    32'(out_rd), 32'd18);
    chk("postrst_op_norm",  out_norm, 32'h0);

    // Randomized run: each unstalled edge moves the op list one place along
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hist.delete();
    hist.push_back('{1'b0, 1'b0, 32'h0, 5'd0});
    hist.push_back('{1'b0, 1'b0, 32'h0, 5'd0});
    for (int c = 0; c < 400; c++) begin
      op_t         cur;
      op_t         exp_o;
      logic        st;
      int          n;
      st     = ($urandom_range(0, 3) == 0);
      cur.v  = ($urandom_range(0, 9) < 7);
      cur.op = 1'($urandom_range(0, 1));
      cur.d  = $urandom >> $urandom_range(0, 32);
      if (cur.op && $urandom_range(0, 1) == 1) cur.d = ~cur.d;
      cur.rd = 5'($urandom_range(0, 31));
      stall  = st;
      drive(cur.v, cur.op, cur.d, cur.rd);
      tick();
      if (!st) begin
        hist.push_back(cur);
        void'(hist.pop_front());
      end
      exp_o = hist[0];
      chk("rnd_valid", 32'(out_valid), 32'(exp_o.v));
      chk("rnd_wen",   32'(out_wen), 32'(exp_o.v && exp_o.rd != 5'd0));
      chk("rnd_busy",  32'(s1_busy), 32'(hist[1].v));
      if (exp_o.v) begin
        n = ref_count(exp_o.op, exp_o.d);
        chk("rnd_count", out_count, 32'(n));
        chk("rnd_norm",  out_norm, ref_norm(exp_o.d, n));
        chk("rnd_rd",    32'(out_rd), 32'(exp_o.rd));
      end
    end
    stall = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
